// File: rtl/shift_seq.sv
// shift_seq: multi-cycle 16-bit shifter, one bit position per clock, valid/ready in and out
module shift_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amt,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             z,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d, step_s;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic c_q, c_d, step_c, accept, shifting;
  always_comb begin
    accept   = in_valid && state_q == IDLE;
    shifting = state_q == SHIFT;
    step_s   = op_q == 2'd0 ? {s_q[WIDTH-2:0], 1'b0} :
               op_q == 2'd1 ? {1'b0, s_q[WIDTH-1:1]} :
               op_q == 2'd2 ? {s_q[WIDTH-1], s_q[WIDTH-1:1]} :
                              {s_q[0], s_q[WIDTH-1:1]};
    step_c   = op_q == 2'd0 ? s_q[WIDTH-1] : s_q[0];
    state_d  = state_q == IDLE  ? (in_valid ? (amt != '0 ? SHIFT : DONE) : IDLE) :
               state_q == SHIFT ? (cnt_q == SHW'(1) ? DONE : SHIFT) :
                                  (out_ready ? IDLE : DONE);
    s_d      = accept ? a : shifting ? step_s : s_q;
    c_d      = accept ? 1'b0 : shifting ? step_c : c_q;
    op_d     = accept ? op : op_q;
    cnt_d    = accept ? amt : shifting ? cnt_q - SHW'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= 1'b0;
      op_q    <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign s         = s_q;
  assign c         = c_q;
  assign z         = s_q == '0;
endmodule
